// File: rtl/mem_arbiter.sv
// mem_arbiter: single RAM port shared by the data port and two ifetch ports.
// Locked grants, data-first with a starvation guard, round-robin between cores.
//
// Ports:
//   CLK, nRST              clock, async active-low reset
//   dREN/dWEN/daddr/dstore data requester; dwait/dload back to it
//   iREN/iaddr             per-core fetch requests; iwait/iload back to them
//   ramREN/ramWEN/ramaddr/ramstore/ramload/ramwait  the RAM port
module mem_arbiter #(
    parameter int WORD_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic                   dREN,
    input  logic                   dWEN,
    input  logic [WORD_W-1:0]      daddr,
    input  logic [WORD_W-1:0]      dstore,
    output logic                   dwait,
    output logic [WORD_W-1:0]      dload,
    input  logic [1:0]             iREN,
    input  logic [1:0][WORD_W-1:0] iaddr,
    output logic [1:0]             iwait,
    output logic [1:0][WORD_W-1:0] iload,
    output logic                   ramREN,
    output logic                   ramWEN,
    output logic [WORD_W-1:0]      ramaddr,
    output logic [WORD_W-1:0]      ramstore,
    input  logic [WORD_W-1:0]      ramload,
    input  logic                   ramwait
);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        INSTR0,
        INSTR1
    } state_t;

    localparam logic [3:0] SMAX = 4'(STARVE_MAX);

    state_t     state_q, state_d;
    logic       rr_q, rr_d;
    logic [3:0] starve_q, starve_d;

    logic   dreq, ireq, pick, gi;
    state_t ipick;

    assign dreq  = dREN | dWEN;
    assign ireq  = |iREN;
    // Preferred core if it is asking, otherwise the other one.
    assign pick  = iREN[rr_q] ? rr_q : ~rr_q;
    assign ipick = pick ? INSTR1 : INSTR0;
    assign gi    = (state_q == INSTR1);

    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        starve_d = starve_q;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        dwait    = 1'b1;
        iwait    = 2'b11;
        dload    = '0;
        iload    = '0;
        unique case (state_q)
            IDLE: begin
                if (ireq && starve_q == SMAX)
                    state_d = ipick;
                else if (dreq)
                    state_d = DATA;
                else if (ireq)
                    state_d = ipick;
            end
            DATA: begin
                // A dropped request aborts: enables fall this cycle.
                if (!dreq) begin
                    state_d = IDLE;
                end else begin
                    ramaddr = daddr;
                    if (dWEN) begin
                        ramWEN   = 1'b1;
                        ramstore = dstore;
                    end else begin
                        ramREN = 1'b1;
                        dload  = ramload;
                    end
                    if (!ramwait) begin
                        dwait   = 1'b0;
                        state_d = IDLE;
                        if (!ireq)
                            starve_d = '0;
                        else if (starve_q != SMAX)
                            starve_d = starve_q + 4'd1;
                    end
                end
            end
            INSTR0, INSTR1: begin
                if (!iREN[gi]) begin
                    state_d = IDLE;
                end else begin
                    ramREN    = 1'b1;
                    ramaddr   = iaddr[gi];
                    iload[gi] = ramload;
                    if (!ramwait) begin
                        iwait[gi] = 1'b0;
                        rr_d      = ~gi;
                        starve_d  = '0;
                        state_d   = IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            rr_q     <= 1'b0;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            starve_q <= starve_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vectors for mem_arbiter.
// RAM returns addr ^ 0xCAFE0000 combinationally.
module tb_mem_arbiter;

    logic             CLK = 1'b0;
    logic             nRST;
    logic             dREN, dWEN;
    logic [31:0]      daddr, dstore;
    logic             dwait;
    logic [31:0]      dload;
    logic [1:0]       iREN;
    logic [1:0][31:0] iaddr;
    logic [1:0]       iwait;
    logic [1:0][31:0] iload;
    logic             ramREN, ramWEN;
    logic [31:0]      ramaddr, ramstore, ramload;
    logic             ramwait;

    int n_vec = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    assign ramload = ramaddr ^ 32'hCAFE_0000;

    mem_arbiter #(.WORD_W(32), .STARVE_MAX(4)) dut (
        .CLK(CLK), .nRST(nRST),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramwait(ramwait)
    );

    function automatic logic [31:0] f(input logic [31:0] a);
        return a ^ 32'hCAFE_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic expect_out(input string tag,
                              input logic ren, input logic wen,
                              input logic [31:0] addr, input logic [31:0] st,
                              input logic dw, input logic [1:0] iw,
                              input logic [31:0] dl,
                              input logic [31:0] il0, input logic [31:0] il1);
        chk({tag, ".ramREN"}, 32'(ramREN), 32'(ren));
        chk({tag, ".ramWEN"}, 32'(ramWEN), 32'(wen));
        chk({tag, ".ramaddr"}, ramaddr, addr);
        chk({tag, ".ramstore"}, ramstore, st);
        chk({tag, ".dwait"}, 32'(dwait), 32'(dw));
        chk({tag, ".iwait"}, 32'(iwait), 32'(iw));
        chk({tag, ".dload"}, dload, dl);
        chk({tag, ".iload0"}, iload[0], il0);
        chk({tag, ".iload1"}, iload[1], il1);
    endtask

    task automatic idle_chk(input string tag);
        expect_out(tag, 0, 0, 0, 0, 1, 2'b11, 0, 0, 0);
    endtask

    task automatic nxt();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        nRST    = 1'b0;
        dREN    = 1'b0;
        dWEN    = 1'b0;
        daddr   = '0;
        dstore  = '0;
        iREN    = 2'b00;
        iaddr   = '0;
        ramwait = 1'b1;
        #1;
        idle_chk("reset");
        nxt();
        nxt();
        nRST = 1'b1;

        // Data write, RAM completes on third DATA cycle
        daddr  = 32'h100;
        dstore = 32'hDEAD_BEEF;
        dWEN   = 1'b1;
        @(negedge CLK);
        idle_chk("wr_idle");
        nxt();
        for (int k = 1; k <= 3; k++) begin
            if (k == 3) ramwait = 1'b0;
            @(negedge CLK);
            expect_out($sformatf("wr_data%0d", k), 0, 1, 32'h100,
                       32'hDEAD_BEEF, (k == 3) ? 1'b0 : 1'b1,
                       2'b11, 0, 0, 0);
            nxt();
        end
        dWEN    = 1'b0;
        ramwait = 1'b1;
        @(negedge CLK);
        idle_chk("wr_done");
        nxt();

        // Round-robin between both cores, zero-wait RAM
        iaddr[0] = 32'h200;
        iaddr[1] = 32'h300;
        iREN     = 2'b11;
        ramwait  = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge CLK);
            if (c % 2 == 0) begin
                idle_chk($sformatf("rr_idle%0d", c));
            end else if (((c / 2) % 2) == 0) begin
                expect_out($sformatf("rr_core0_%0d", c), 1, 0, 32'h200,
                           0, 1, 2'b10, 0, f(32'h200), 0);
            end else begin
                expect_out($sformatf("rr_core1_%0d", c), 1, 0, 32'h300,
                           0, 1, 2'b01, 0, 0, f(32'h300));
            end
            nxt();
        end
        iREN = 2'b00;
        @(negedge CLK);
        idle_chk("rr_end");
        nxt();

        // Starvation guard: 4 data reads then one core1 fetch, twice
        daddr    = 32'h400;
        dREN     = 1'b1;
        iaddr[1] = 32'h500;
        iREN     = 2'b10;
        for (int c = 0; c < 20; c++) begin
            @(negedge CLK);
            if (c % 2 == 0) begin
                idle_chk($sformatf("sv_idle%0d", c));
            end else if (c / 2 == 4 || c / 2 == 9) begin
                expect_out($sformatf("sv_fetch%0d", c), 1, 0, 32'h500,
                           0, 1, 2'b01, 0, 0, f(32'h500));
            end else begin
                expect_out($sformatf("sv_data%0d", c), 1, 0, 32'h400,
                           0, 0, 2'b11, f(32'h400), 0, 0);
            end
            nxt();
        end
        dREN = 1'b0;
        iREN = 2'b00;
        @(negedge CLK);
        idle_chk("sv_end");
        nxt();

        // Read and write together -> write
        daddr  = 32'h600;
        dstore = 32'h1234_5678;
        dREN   = 1'b1;
        dWEN   = 1'b1;
        @(negedge CLK);
        idle_chk("rw_idle");
        nxt();
        @(negedge CLK);
        expect_out("rw_data", 0, 1, 32'h600, 32'h1234_5678,
                   0, 2'b11, 0, 0, 0);
        nxt();
        dREN = 1'b0;
        dWEN = 1'b0;
        @(negedge CLK);
        idle_chk("rw_end");
        nxt();

        // Core0 fetch abort; rr must stay on core0
        iaddr[0] = 32'h700;
        iaddr[1] = 32'h300;
        iREN     = 2'b01;
        ramwait  = 1'b1;
        @(negedge CLK);
        idle_chk("ab_idle");
        nxt();
        @(negedge CLK);
        expect_out("ab_fetch", 1, 0, 32'h700, 0, 1, 2'b11,
                   0, f(32'h700), 0);
        nxt();
        iREN = 2'b00;
        @(negedge CLK);
        idle_chk("ab_drop");
        nxt();
        @(negedge CLK);
        idle_chk("ab_after");
        nxt();
        iREN    = 2'b11;
        ramwait = 1'b0;
        @(negedge CLK);
        idle_chk("ab_rr_idle");
        nxt();
        @(negedge CLK);
        expect_out("ab_rr_core0", 1, 0, 32'h700, 0, 1, 2'b10,
                   0, f(32'h700), 0);
        nxt();
        iREN = 2'b00;
        @(negedge CLK);
        idle_chk("ab_end");
        nxt();

        // Async reset mid data access
        daddr   = 32'h800;
        dREN    = 1'b1;
        ramwait = 1'b1;
        @(negedge CLK);
        idle_chk("rs_idle");
        nxt();
        @(negedge CLK);
        expect_out("rs_data", 1, 0, 32'h800, 0, 1, 2'b11,
                   f(32'h800), 0, 0);
        nxt();
        #1;
        nRST = 1'b0;
        #1;
        idle_chk("rs_async");
        nxt();
        nRST    = 1'b1;
        ramwait = 1'b0;
        @(negedge CLK);
        idle_chk("rs_rel_idle");
        nxt();
        @(negedge CLK);
        expect_out("rs_regrant", 1, 0, 32'h800, 0, 0, 2'b11,
                   f(32'h800), 0, 0);
        nxt();
        dREN = 1'b0;
        @(negedge CLK);
        idle_chk("rs_end");
        nxt();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter between the coherence bus controller's data port and the two cores' instruction-fetch ports. It sits below the bus controller and the icaches and owns the one RAM port. Grants are locked for a whole access. Data has priority, with a starvation guard so instruction fetch always makes progress. The two instruction requesters share round-robin priority.

## Interface
- WORD_W, 32, data/address width
- STARVE_MAX, 4, consecutive data grants allowed while any instruction request is pending (1–15)

- CLK  in  1  clock, rising edge
- nRST  in  1  reset, asynchronous, active-low
- dREN  in  1  data read request from bus controller
- dWEN  in  1  data write request from bus controller
- daddr  in  WORD_W  data address
- dstore  in  WORD_W  data write value
- dwait  out  1  0 for exactly the completing cycle of a data access, else 1
- dload  out  WORD_W  read data; ramload while a data read is granted, else 0
- iREN  in  2  instruction read request, per core
- iaddr  in  2×WORD_W  instruction address, per core
- iwait  out  2  per-core wait; bit i is 0 only in core i's completing cycle
- iload  out  2×WORD_W  per-core fetch data; ramload when that core is granted, else 0
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  WORD_W  RAM address
- ramstore  out  WORD_W  RAM write data
- ramload  in  WORD_W  RAM read data
- ramwait  in  1  1 while the current RAM access is incomplete

## Operation
- States: IDLE, DATA, INSTR0, INSTR1. Registers: state, rr (1 bit, preferred core), starve (4-bit count).
- IDLE: RAM enables 0. Grant selection:
  - If any iREN is set and starve == STARVE_MAX, choose an instruction grant.
  - Else if dREN or dWEN is set, go to DATA.
  - Else if any iREN is set, choose an instruction grant.
  - Instruction grant picks core rr if iREN[rr] is set, otherwise the other core.
  - No request: stay in IDLE.
- DATA: drive ramaddr=daddr.
  - If dWEN: ramWEN=1, ramstore=dstore.
  - Else: ramREN=1.
  - If dREN and dWEN are both set, the access is a write.
  - When ramwait=0: dwait=0, go to IDLE.
  - starve increments on completion, saturating at STARVE_MAX, only if any iREN was set in that cycle. Otherwise starve clears.
- INSTRi: ramREN=1, ramaddr=iaddr[i].
  - When ramwait=0: iwait[i]=0, rr = !i, starve=0, go to IDLE.
- Abort: if the granted requester drops its request (dREN=dWEN=0 in DATA, or iREN[i]=0 in INSTRi) before completion:
  - RAM enables drop combinationally that cycle.
  - Go to IDLE.
  - All waits stay 1.
  - starve and rr are unchanged.
- The address and data of a granted requester are read combinationally each cycle. Requesters must hold them stable until their wait goes low.
- ramstore=0 except during a DATA write. ramaddr=0 in IDLE.
- Reset (asynchronous, any state, including mid-access):
  - state=IDLE, rr=0, starve=0.
  - All RAM enables, ramaddr and ramstore are 0.
  - dwait=1, iwait=2'b11, dload=iload=0.
  - The in-flight access is abandoned with no completion pulse.

## Timing
- Request first seen in IDLE at cycle N: RAM is driven from cycle N+1.
- Completion falls in the first cycle C ≥ N+1 with ramwait=0. The requester's wait is low in cycle C only, and load data is valid in the same cycle.
- Minimum access latency is 2 cycles (zero-wait RAM). Exactly one IDLE bubble separates back-to-back accesses, so peak throughput is 1 access per 2 cycles.
- Grant decisions use only values sampled in IDLE. Requests arriving mid-access wait for the next IDLE.
- A requester holding its request after its completion pulse is treated as a new request in the following IDLE.
- No output is driven by combinational logic from another requester's inputs.

## Test plan
- Single data write, daddr=0x100, dstore=0xDEADBEEF, ramwait low on the 3rd cycle of DATA → ramWEN=1 for 3 cycles with correct addr/data; dwait=0 in that cycle only; return to IDLE.
- iREN=2'b11 continuously, zero-wait RAM, 8 cycles → grant order core0, core1, core0, core1; each iwait pulse carries ramload for that core's iaddr.
- dREN held continuously, iREN[1]=1, STARVE_MAX=4 → 4 data completions, then one INSTR1 completion, then data resumes; starve=0 after the fetch.
- dREN=dWEN=1 simultaneously → a write is performed (ramWEN=1, ramREN=0); dload=0.
- iREN[0] dropped mid-access while ramwait=1 → ramREN=0 that cycle, no iwait pulse, IDLE next cycle, rr still 0.
- nRST asserted during DATA with ramwait=1 → asynchronously ramREN=ramWEN=0, dwait=1, state IDLE; after release, the pending dREN is granted with the standard 2-cycle latency.
